// File: rtl/datapath.sv
// datapath: execution datapath driven cycle-by-cycle by the CPU controller.
// Holds the instruction register, an 8x16 register file, the A/B/C pipeline
// registers, the B-side shifter, the ALU and the Z/N/V status register.
// It has no sequencing of its own; every state change is caused by a strobe.
// Optional feature macro: DATAPATH_OVF_EN (signed-overflow flag V). When it
// is not defined, no overflow logic exists and V_out stays 0.
module datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [3:0]  vsel,
  input  logic [2:0]  nsel,
  input  logic        write,
  input  logic        loada,
  input  logic        loadb,
  input  logic        asel,
  input  logic        bsel,
  input  logic        loadc,
  input  logic        loads,
  input  logic [15:0] mdata,
  input  logic [7:0]  PC,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [15:0] datapath_out,
  output logic        Z_out,
  output logic        N_out,
  output logic        V_out
);

  logic [15:0] ir;
  logic [15:0] rf [8];
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [15:0] c_reg;
  logic        z_reg;
  logic        n_reg;
  logic        v_reg;

  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [2:0]  rm;
  logic [1:0]  shift;
  logic [1:0]  alu_op;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  logic [2:0]  rf_idx;
  logic [15:0] rf_rdata;
  logic [15:0] rf_wdata;
  logic [15:0] b_shifted;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_res;
  logic        alu_ovf;

  // Instruction field decode; always reflects the IR as it stands this cycle.
  always_comb begin
    rn     = ir[10:8];
    rd     = ir[7:5];
    rm     = ir[2:0];
    shift  = ir[4:3];
    alu_op = ir[12:11];
    sximm8 = {{8{ir[7]}}, ir[7:0]};
    sximm5 = {{11{ir[4]}}, ir[4:0]};
  end

  assign opcode = ir[15:13];
  assign op     = ir[12:11];

  // Register index select; anything that is not one-hot falls back to R0.
  always_comb begin
    rf_idx = 3'd0;
    case (nsel)
      3'b100:  rf_idx = rn;
      3'b010:  rf_idx = rd;
      3'b001:  rf_idx = rm;
      default: rf_idx = 3'd0;
    endcase
  end

  assign rf_rdata = rf[rf_idx];

  // Writeback source select; an invalid select writes zero.
  always_comb begin
    rf_wdata = 16'h0000;
    case (vsel)
      4'b0001: rf_wdata = c_reg;
      4'b0010: rf_wdata = {8'h00, PC};
      4'b0100: rf_wdata = sximm8;
      4'b1000: rf_wdata = mdata;
      default: rf_wdata = 16'h0000;
    endcase
  end

  // Single-bit shifter on the B operand.
  always_comb begin
    b_shifted = b_reg;
    case (shift)
      2'b00: b_shifted = b_reg;
      2'b01: b_shifted = {b_reg[14:0], 1'b0};
      2'b10: b_shifted = {1'b0, b_reg[15:1]};
      2'b11: b_shifted = {b_reg[15], b_reg[15:1]};
      default: b_shifted = b_reg;
    endcase
  end

  // ALU operand selection and the ALU itself (results wrap modulo 2^16).
  always_comb begin
    alu_a   = asel ? 16'h0000 : a_reg;
    alu_b   = bsel ? sximm5 : b_shifted;
    alu_res = 16'h0000;
    case (alu_op)
      2'b00: alu_res = alu_a + alu_b;
      2'b01: alu_res = alu_a - alu_b;
      2'b10: alu_res = alu_a & alu_b;
      2'b11: alu_res = ~alu_b;
      default: alu_res = 16'h0000;
    endcase
  end

`ifdef DATAPATH_OVF_EN
  // Signed overflow: operands effectively of equal sign whose result flips sign.
  always_comb begin
    alu_ovf = 1'b0;
    case (alu_op)
      2'b00: alu_ovf = (alu_a[15] == alu_b[15]) && (alu_res[15] != alu_a[15]);
      2'b01: alu_ovf = (alu_a[15] != alu_b[15]) && (alu_res[15] != alu_a[15]);
      default: alu_ovf = 1'b0;
    endcase
  end
`else
  assign alu_ovf = 1'b0;
`endif

  // All state; reset overrides every strobe, reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir    <= 16'h0000;
      a_reg <= 16'h0000;
      b_reg <= 16'h0000;
      c_reg <= 16'h0000;
      z_reg <= 1'b0;
      n_reg <= 1'b0;
      v_reg <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
    end else begin
      if (load)  ir    <= in;
      if (write) rf[rf_idx] <= rf_wdata;
      if (loada) a_reg <= rf_rdata;
      if (loadb) b_reg <= rf_rdata;
      if (loadc) c_reg <= alu_res;
      if (loads) begin
        z_reg <= (alu_res == 16'h0000);
        n_reg <= alu_res[15];
        v_reg <= alu_ovf;
      end
    end
  end

  assign datapath_out = c_reg;
  assign Z_out        = z_reg;
  assign N_out        = n_reg;
  assign V_out        = v_reg;

endmodule
